// File: rtl/button_conditioner.sv
// button_conditioner: sync + debounce + rising-edge pulse per button; optional auto-repeat under AUTO_REPEAT_EN
module button_conditioner #(
  parameter int N_BUTTONS = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter logic [N_BUTTONS-1:0] REPEAT_MASK = 3'b011
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_pulse,
  output logic [N_BUTTONS-1:0] btn_level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [N_BUTTONS-1:0] s1, s2, level_d, rep;
  // two-flop synchroniser, level history and registered pulse
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      level_d <= '0;
      btn_pulse <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      level_d <= btn_level;
      btn_pulse <= (btn_level & ~level_d) | rep;
    end
`ifdef AUTO_REPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = RMAX > 1 ? $clog2(RMAX) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_FIRST, REPEAT} state_t;
`endif
  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic lvl;
    assign btn_level[i] = lvl;
    // accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2[i] == lvl) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl <= s2[i];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
`ifdef AUTO_REPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      state_t state;
      logic [RW-1:0] rcnt;
      logic fire;
      always_comb fire = lvl && state != IDLE &&
                         rcnt == (state == WAIT_FIRST ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1));
      assign rep[i] = fire;
      // repeat timer: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD while held
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          state <= IDLE;
          rcnt <= '0;
        end else if (!lvl) begin
          state <= IDLE;
          rcnt <= '0;
        end else if (!level_d[i]) begin
          state <= WAIT_FIRST;
          rcnt <= '0;
        end else if (fire) begin
          state <= REPEAT;
          rcnt <= '0;
        end else if (state != IDLE) rcnt <= rcnt + 1'b1;
    end else begin : g_norep
      assign rep[i] = 1'b0;
    end
`else
    assign rep[i] = 1'b0;
`endif
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed spec scenarios plus random stimulus against a sliding-window reference model
module tb_button_conditioner;
  localparam int D = 4, RD = 8, RP = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] btn_raw = '0, btn_pulse, btn_level;
  logic [2:0] mask = 3'b011;
  int n_cmp = 0, n_err = 0;
  logic [2:0] p1, p2, lv, lvd, exp_pulse;
  logic [2:0] win[$];
  int e = 0;
  int press_e[3];
  bit active[3];
  always #5 clk = ~clk;
  button_conditioner #(.N_BUTTONS(3), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
                       .REPEAT_MASK(3'b011))
    dut (.clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_pulse(btn_pulse), .btn_level(btn_level));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    p1 = '0; p2 = '0; lv = '0; lvd = '0; exp_pulse = '0;
    win = {};
    for (int j = 0; j < D; j++) win.push_back(3'b000);
    for (int i = 0; i < 3; i++) active[i] = 0;
  endtask
  // level flips once the last D synchronised samples all differ from it;
  // pulse marks a 0->1 level change one cycle later, plus timed repeats while held
  task automatic model_edge();
    logic [2:0] s, nlv, rise;
    int k;
    bit all;
    s = p2; p2 = p1; p1 = btn_raw;
    win.push_back(s);
    void'(win.pop_front());
    nlv = lv;
    for (int i = 0; i < 3; i++) begin
      all = 1;
      foreach (win[j]) if (win[j][i] == lv[i]) all = 0;
      if (all) nlv[i] = ~lv[i];
    end
    rise = lv & ~lvd;
    exp_pulse = rise;
    for (int i = 0; i < 3; i++) begin
      if (rise[i]) begin
        active[i] = 1;
        press_e[i] = e;
      end else if (!lv[i]) active[i] = 0;
`ifdef AUTO_REPEAT_EN
      else if (mask[i] && active[i]) begin
        k = e - press_e[i];
        if (k == RD || (k > RD && (k - RD) % RP == 0)) exp_pulse[i] = 1'b1;
      end
`endif
    end
    lvd = lv; lv = nlv; e++;
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst) model_edge(); else model_reset();
    #1;
    check("level", btn_level, lv);
    check("pulse", btn_pulse, exp_pulse);
  endtask
  initial begin
    int first, lrise, cnt, any, last_one;
    int hold[3];
    int edges[$];
    model_reset();
    repeat (3) tick();
    check("reset_out", {btn_level, btn_pulse}, 0);
    rst = 1'b1;
    // clean press on left
    btn_raw = 3'b001; first = -1; lrise = -1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn_level[0] && lrise < 0) lrise = c;
      if (btn_pulse[0]) begin cnt++; if (first < 0) first = c; end
    end
    check("clean_level_edge", lrise, 5);
    check("clean_pulse_edge", first, 6);
    check("clean_pulse_count", cnt, 1);
    btn_raw = 3'b000;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin tick(); if (btn_pulse != 0) cnt++; end
    check("release_no_pulse", cnt, 0);
    // bounce on put
    cnt = 0;
    foreach (edges[j]) edges.delete();
    for (int c = 0; c < 5; c++) begin
      btn_raw[2] = (c % 2 == 0);
      tick();
      if (btn_pulse != 0) cnt++;
    end
    check("bounce_toggle_no_pulse", cnt, 0);
    first = -1; cnt = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (btn_pulse[2]) begin cnt++; if (first < 0) first = c; end
    end
    check("bounce_pulse_offset", first, 6);
    check("bounce_pulse_count", cnt, 1);
    btn_raw = 3'b000;
    repeat (10) tick();
    // short glitch on right
    any = 0;
    btn_raw[1] = 1'b1;
    repeat (3) begin tick(); any |= {btn_level, btn_pulse}; end
    btn_raw[1] = 1'b0;
    repeat (10) begin tick(); any |= {btn_level, btn_pulse}; end
    check("glitch_quiet", any, 0);
    // simultaneous press and release
    btn_raw = 3'b111; first = -1; cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (btn_pulse != 0) begin cnt++; if (first < 0) first = btn_pulse; end
    end
    check("simul_pulse_value", first, 3'b111);
    check("simul_pulse_count", cnt, 1);
    btn_raw = 3'b000; cnt = 0;
    for (int c = 0; c < 12; c++) begin tick(); if (btn_pulse != 0) cnt++; end
    check("simul_release", cnt, 0);
    // reset mid-press
    btn_raw = 3'b001; cnt = 0;
    while (!btn_level[0] && cnt < 20) begin tick(); cnt++; end
    check("midpress_level_seen", btn_level[0], 1'b1);
    rst = 1'b0;
    #1;
    check("midpress_async_clear", {btn_level, btn_pulse}, 0);
    model_reset();
    repeat (2) tick();
    rst = 1'b1; first = -1; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (btn_pulse[0]) begin cnt++; if (first < 0) first = c; end
    end
    check("midpress_pulse_edge", first, 6);
    check("midpress_pulse_count", cnt, 1);
    btn_raw = 3'b000;
    repeat (10) tick();
    // long hold on left and put
    btn_raw = 3'b001;
    edges = {};
    for (int c = 0; c < 30; c++) begin tick(); if (btn_pulse[0]) edges.push_back(c); end
`ifdef AUTO_REPEAT_EN
    check("hold_left_count", edges.size(), 7);
    for (int j = 0; j < edges.size() && j < 7; j++)
      check("hold_left_edge", edges[j], j == 0 ? 6 : 14 + (j - 1) * RP);
`else
    check("hold_left_count", edges.size(), 1);
`endif
    btn_raw = 3'b000;
    repeat (10) tick();
    btn_raw = 3'b100; cnt = 0;
    for (int c = 0; c < 30; c++) begin tick(); if (btn_pulse[2]) cnt++; end
    check("hold_put_count", cnt, 1);
    btn_raw = 3'b000;
    repeat (10) tick();
    // random activity with occasional resets
    for (int i = 0; i < 3; i++) hold[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < 3; i++)
        if (hold[i] == 0) begin
          btn_raw[i] = 1'($urandom_range(0, 1));
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 6));
        end else hold[i]--;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        #1;
        check("rand_async_clear", {btn_level, btn_pulse}, 0);
        tick();
        rst = 1'b1;
      end
      tick();
    end
    last_one = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + last_one);
    $finish;
  end
endmodule
